// File: rtl/apb_gpio_ext.sv
// APB3 GPIO controller: per-pin direction, atomic set/clear outputs, synchronised and
// debounced inputs, and per-pin level/edge interrupts with write-one-to-clear status.
module apb_gpio_ext #(
    parameter int unsigned        IO_NUM  = 8,
    parameter int unsigned        DB_W    = 16,
    parameter logic [IO_NUM-1:0]  OUT_RST = {IO_NUM{1'b0}},
    parameter logic [IO_NUM-1:0]  DIR_RST = {IO_NUM{1'b0}}
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [7:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [IO_NUM-1:0] GPIO_IN,
    output logic [IO_NUM-1:0] GPIO_OUT,
    output logic [IO_NUM-1:0] GPIO_OE,
    output logic [IO_NUM-1:0] INT,
    output logic              INT_OR
);

    localparam logic [5:0] A_DATA_OUT = 6'd0;
    localparam logic [5:0] A_OUT_SET  = 6'd1;
    localparam logic [5:0] A_OUT_CLR  = 6'd2;
    localparam logic [5:0] A_DIR      = 6'd3;
    localparam logic [5:0] A_DATA_IN  = 6'd4;
    localparam logic [5:0] A_INT_EN   = 6'd5;
    localparam logic [5:0] A_INT_MODE = 6'd6;
    localparam logic [5:0] A_INT_POL  = 6'd7;
    localparam logic [5:0] A_INT_BOTH = 6'd8;
    localparam logic [5:0] A_INT_STAT = 6'd9;
    localparam logic [5:0] A_DEBOUNCE = 6'd10;

    logic [IO_NUM-1:0] out_q, out_d, dir_q, dir_d;
    logic [IO_NUM-1:0] en_q, en_d, mode_q, mode_d, pol_q, pol_d, both_q, both_d;
    logic [IO_NUM-1:0] stat_q, stat_d;
    logic [DB_W-1:0]   db_q, db_d, div_q, div_d;
    logic [IO_NUM-1:0] s1_q, s1_d, s2_q, s2_d, h0_q, h0_d, h1_q, h1_d;
    logic [IO_NUM-1:0] filt_q, filt_d, prev_q, prev_d;

    logic [5:0]        word_s;
    logic              mapped_s;
    logic              wr_s;
    logic              db_wr_s;
    logic              tick_s;
    logic [31:0]       rd_s;
    logic [IO_NUM-1:0] wdata_s;
    logic [IO_NUM-1:0] w1c_s;
    logic [IO_NUM-1:0] agree_s;
    logic [IO_NUM-1:0] rise_s, fall_s, edge_ev_s, lvl_ev_s, ev_s;
    logic              unused_s;

    assign word_s   = PADDR[7:2];
    assign wdata_s  = PWDATA[IO_NUM-1:0];
    assign wr_s     = PSEL & PENABLE & PWRITE & mapped_s;
    assign db_wr_s  = wr_s & (word_s == A_DEBOUNCE);
    assign unused_s = ^{PADDR[1:0], PWDATA};

    // Address decode and read mux; write-only and unmapped words read zero.
    always_comb begin
        mapped_s = 1'b1;
        rd_s     = 32'h0000_0000;
        case (word_s)
            A_DATA_OUT: rd_s[IO_NUM-1:0] = out_q;
            A_OUT_SET:  rd_s = 32'h0000_0000;
            A_OUT_CLR:  rd_s = 32'h0000_0000;
            A_DIR:      rd_s[IO_NUM-1:0] = dir_q;
            A_DATA_IN:  rd_s[IO_NUM-1:0] = filt_q;
            A_INT_EN:   rd_s[IO_NUM-1:0] = en_q;
            A_INT_MODE: rd_s[IO_NUM-1:0] = mode_q;
            A_INT_POL:  rd_s[IO_NUM-1:0] = pol_q;
            A_INT_BOTH: rd_s[IO_NUM-1:0] = both_q;
            A_INT_STAT: rd_s[IO_NUM-1:0] = stat_q;
            A_DEBOUNCE: rd_s[DB_W-1:0] = db_q;
            default:    mapped_s = 1'b0;
        endcase
    end

    // APB response: read data and error are forced quiet while reset is held.
    always_comb begin
        if (PSEL & ~PWRITE & ~PRESET) begin
            PRDATA = rd_s;
        end else begin
            PRDATA = 32'h0000_0000;
        end
        PSLVERR = PSEL & PENABLE & ~mapped_s & ~PRESET;
        PREADY  = 1'b1;
    end

    // Register write decode; the status clear mask is applied later against new events.
    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        en_d   = en_q;
        mode_d = mode_q;
        pol_d  = pol_q;
        both_d = both_q;
        db_d   = db_q;
        w1c_s  = {IO_NUM{1'b0}};
        if (wr_s) begin
            case (word_s)
                A_DATA_OUT: out_d  = wdata_s;
                A_OUT_SET:  out_d  = out_q | wdata_s;
                A_OUT_CLR:  out_d  = out_q & ~wdata_s;
                A_DIR:      dir_d  = wdata_s;
                A_INT_EN:   en_d   = wdata_s;
                A_INT_MODE: mode_d = wdata_s;
                A_INT_POL:  pol_d  = wdata_s;
                A_INT_BOTH: both_d = wdata_s;
                A_INT_STAT: w1c_s  = wdata_s;
                A_DEBOUNCE: db_d   = PWDATA[DB_W-1:0];
                default:    out_d  = out_q;
            endcase
        end else begin
            w1c_s = {IO_NUM{1'b0}};
        end
    end

    // Shared debounce divider: ticks when the count reaches DEBOUNCE, restarts on a write.
    always_comb begin
        tick_s = (div_q == db_q);
        if (db_wr_s) begin
            div_d = {DB_W{1'b0}};
        end else if (tick_s) begin
            div_d = {DB_W{1'b0}};
        end else begin
            div_d = div_q + DB_W'(1'b1);
        end
    end

    // Synchroniser and filter: a level must be seen on three consecutive ticks.
    always_comb begin
        s1_d    = GPIO_IN;
        s2_d    = s1_q;
        agree_s = ~(h1_q ^ h0_q) & ~(h0_q ^ s2_q);
        if (tick_s) begin
            h0_d   = s2_q;
            h1_d   = h0_q;
            filt_d = (filt_q & ~agree_s) | (s2_q & agree_s);
        end else begin
            h0_d   = h0_q;
            h1_d   = h1_q;
            filt_d = filt_q;
        end
        prev_d = filt_q;
    end

    // Interrupt events; a new event outranks a same-cycle clear so held levels stay set.
    always_comb begin
        rise_s    = filt_q & ~prev_q;
        fall_s    = ~filt_q & prev_q;
        edge_ev_s = (both_q & (rise_s | fall_s))
                  | (~both_q & ((pol_q & rise_s) | (~pol_q & fall_s)));
        lvl_ev_s  = ~(filt_q ^ pol_q);
        ev_s      = (mode_q & edge_ev_s) | (~mode_q & lvl_ev_s);
        stat_d    = (stat_q & ~w1c_s) | (ev_s & en_q);
    end

    // State registers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            out_q  <= OUT_RST;
            dir_q  <= DIR_RST;
            en_q   <= {IO_NUM{1'b0}};
            mode_q <= {IO_NUM{1'b0}};
            pol_q  <= {IO_NUM{1'b0}};
            both_q <= {IO_NUM{1'b0}};
            stat_q <= {IO_NUM{1'b0}};
            db_q   <= {DB_W{1'b0}};
            div_q  <= {DB_W{1'b0}};
            s1_q   <= {IO_NUM{1'b0}};
            s2_q   <= {IO_NUM{1'b0}};
            h0_q   <= {IO_NUM{1'b0}};
            h1_q   <= {IO_NUM{1'b0}};
            filt_q <= {IO_NUM{1'b0}};
            prev_q <= {IO_NUM{1'b0}};
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            en_q   <= en_d;
            mode_q <= mode_d;
            pol_q  <= pol_d;
            both_q <= both_d;
            stat_q <= stat_d;
            db_q   <= db_d;
            div_q  <= div_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            h0_q   <= h0_d;
            h1_q   <= h1_d;
            filt_q <= filt_d;
            prev_q <= prev_d;
        end
    end

    assign GPIO_OUT = out_q;
    assign GPIO_OE  = dir_q;
    assign INT      = stat_q & en_q;
    assign INT_OR   = |INT;

endmodule
